ifu: RTL
========

// Module: ifu
// PURPOSE
//  Instruction fetch unit directly upstream of the control unit (cu). Holds the PC and IR.
//  Updates the PC from cu ps selects, prefetches the instruction at PC over a req/ack
//  instruction-memory interface into a one-entry buffer, and loads IR on cu il.
//  hold_out freezes cu/datapath while an il_in load waits on memory.
// PARAMETERS
//  PC_W      16      PC / imem address width; PC arithmetic wraps mod 2**PC_W
//  RESET_PC  '0      PC value after reset (PC_W bits)
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst            in   1     synchronous, active-high reset
//  ps_in          in   2     PC select from cu: 00 hold, 01 PC+1, 10 PC+offset, 11 PC<=a_in
//  il_in          in   1     instruction load request from cu
//  a_in           in   PC_W  jump target (register A from datapath)
//  imem_req_out   out  1     fetch request
//  imem_addr_out  out  PC_W  fetch address, stable while imem_req_out=1
//  imem_ack_in    in   1     fetch accepted + data valid this cycle
//  imem_rdata_in  in   16    fetched instruction
//  ins_out        out  16    IR contents -> cu ins_in
//  pc_out         out  PC_W  current PC
//  hold_out       out  1     stall: il_in pending, instruction not yet available
//  stall_cnt_out  out  16    hold-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at edge): pc_r<=RESET_PC, ir_r<=0, buf invalid, req_addr_r<=RESET_PC,
//   state<=REQ. Next cycle: imem_req_out=1, imem_addr_out=RESET_PC, ins_out=0, hold_out=il_in.
//   rst mid-transaction aborts; a late ack after reset is accepted as a fresh REQ response.
//  Handshake: a transaction completes on the cycle imem_req_out=1 and imem_ack_in=1.
//   req and addr held until ack. ack with req=0 is ignored. A new req may start the next cycle.
//  FSM (3 states):
//   REQ : req=1, addr=req_addr_r. On ack: buf<=rdata -> FULL.
//   FULL: req=0. buf holds instruction at pc_r.
//   DROP: req=1, addr=req_addr_r (stale PC). On ack: data discarded, req_addr_r<=pc_r -> REQ.
//  PC update (when ps_in!=00 and hold_out=0) takes effect at the edge.
//   Next PC: 01 pc+1; 10 pc+sext6({ins_out[8:6],ins_out[2:0]}); 11 a_in[PC_W-1:0].
//   All arithmetic PC_W bits, overflow discarded (FFFF+1=0000).
//   State transitions on PC update:
//    FULL -> REQ with req_addr_r<=next PC.
//    REQ with no ack this cycle -> DROP (address must stay stable).
//    REQ with ack this cycle -> REQ with the new address (data discarded).
//    DROP -> DROP.
//  IR load (il_in=1):
//   FULL: ir_r<=buf, hold_out=0.
//   REQ with ack: ir_r<=imem_rdata_in same edge, hold_out=0.
//   Otherwise (REQ no ack, DROP): hold_out=1 (combinational), ir_r unchanged.
//   While hold_out=1, ps_in is ignored.
//  il_in and ps_in!=00 in the same cycle: IR loads first, then the PC update applies.
//   Both occur at the same edge; the offset uses the old ins_out.
//  Latency: il_in to ins_out is 1 cycle when the instruction is buffered.
//   Otherwise it is 1 cycle after the ack.
// CONFIGURATION
//  IFU_STALL_CNT_EN defined: stall_cnt_out counts cycles with hold_out=1.
//   Saturates at 16'hFFFF; cleared by rst.
//  Not defined: counter logic removed, stall_cnt_out tied 16'h0000.
// TESTING
//  1 rst 2 cycles, ack 3 cycles after req -> req=1 addr=0000 throughout; il_in during wait
//    -> hold_out=1 until ack cycle; ins_out=rdata (e.g. 16'h1A05) next cycle.
//  2 FULL with buf=16'h0C42, il_in=1 -> hold_out=0; ins_out=16'h0C42 next cycle; req stays 0.
//  3 pc=0000, ins_out[8:6]=111, [2:0]=111, ps_in=10 -> pc_out=FFFF.
//    Then ps_in=01 -> pc_out=0000 (wrap).
//  4 REQ for addr 0010 no ack; ps_in=11, a_in=0040 -> addr stays 0010 until ack, data discarded;
//    next req addr=0040; IR never loaded with stale data.
//  5 ps_in=00 for 10 cycles in FULL -> pc_out, ins_out, imem_req_out constant; spurious ack ignored.
//  6 IFU_STALL_CNT_EN: 5 hold cycles -> stall_cnt_out=5; rst -> 0.
//    Without the macro -> stall_cnt_out stays 0.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: PC, IR and a one-entry prefetch buffer on a req/ack imem port.
// Optional hold-cycle counter enabled by defining IFU_STALL_CNT_EN.
module ifu #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ps_in,
  input  logic            il_in,
  input  logic [PC_W-1:0] a_in,
  output logic            imem_req_out,
  output logic [PC_W-1:0] imem_addr_out,
  input  logic            imem_ack_in,
  input  logic [15:0]     imem_rdata_in,
  output logic [15:0]     ins_out,
  output logic [PC_W-1:0] pc_out,
  output logic            hold_out,
  output logic [15:0]     stall_cnt_out
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_addr_q, req_addr_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     buf_q, buf_d;

  logic            fetch_req;
  logic            fetch_done;
  logic            ir_ready;
  logic            hold;
  logic            pc_upd;
  logic [PC_W-1:0] pc_offset;
  logic [PC_W-1:0] pc_next;

  always_comb begin
    fetch_req  = (state_q == ST_REQ) || (state_q == ST_DROP);
    fetch_done = fetch_req && imem_ack_in;
    // The instruction at pc_q is usable now if buffered or arriving this cycle.
    ir_ready   = (state_q == ST_FULL) || ((state_q == ST_REQ) && imem_ack_in);
    hold       = il_in && !ir_ready;
    pc_upd     = (ps_in != 2'b00) && !hold;
    pc_offset  = {{(PC_W-6){ir_q[8]}}, ir_q[8:6], ir_q[2:0]};
  end

  always_comb begin
    pc_next = pc_q;
    case (ps_in)
      2'b01:   pc_next = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      2'b10:   pc_next = pc_q + pc_offset;
      2'b11:   pc_next = a_in;
      default: pc_next = pc_q;
    endcase
    pc_d = pc_upd ? pc_next : pc_q;
  end

  always_comb begin
    ir_d = ir_q;
    if (il_in && !hold) begin
      ir_d = (state_q == ST_FULL) ? buf_q : imem_rdata_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    buf_d      = buf_q;
    case (state_q)
      ST_REQ: begin
        if (fetch_done) begin
          if (pc_upd) begin
            req_addr_d = pc_d;
          end else begin
            buf_d   = imem_rdata_in;
            state_d = ST_FULL;
          end
        end else if (pc_upd) begin
          // Address must stay stable until the outstanding fetch is acknowledged.
          state_d = ST_DROP;
        end
      end
      ST_FULL: begin
        if (pc_upd) begin
          req_addr_d = pc_d;
          state_d    = ST_REQ;
        end
      end
      ST_DROP: begin
        if (fetch_done) begin
          req_addr_d = pc_d;
          state_d    = ST_REQ;
        end
      end
      default: begin
        req_addr_d = pc_q;
        state_d    = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ir_q       <= 16'h0000;
      buf_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ir_q       <= ir_d;
      buf_q      <= buf_d;
    end
  end

`ifdef IFU_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`else
  assign stall_cnt_out = 16'h0000;
`endif

  assign imem_req_out  = fetch_req;
  assign imem_addr_out = req_addr_q;
  assign ins_out       = ir_q;
  assign pc_out        = pc_q;
  assign hold_out      = hold;

endmodule
